// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
// Imported by the pair FIFO and the feeder top level.
package fetch_pkg;

   localparam int          INSTR_W = 32;
   localparam logic [31:0] PC_STEP = 32'd4;

   typedef enum logic [1:0] {
      FETCH_IDLE,
      FETCH_WAIT,
      FETCH_DRAIN
   } fetch_state_t;

endpackage

// File: rtl/instr_pair_fifo.sv
// Word FIFO with one-word push, 0/1/2-word pop and two head read ports.
// Heads read as zero when the corresponding entry is not present.
module instr_pair_fifo
   import fetch_pkg::*;
#(
   parameter  int DEPTH = 8,
   localparam int AW    = $clog2(DEPTH),
   localparam int CW    = AW + 1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               i_clr,
   input  logic               i_push,
   input  logic [INSTR_W-1:0] i_wdata,
   input  logic [1:0]         i_pop_n,
   output logic [INSTR_W-1:0] o_head0,
   output logic [INSTR_W-1:0] o_head1,
   output logic [CW-1:0]      o_count
);

   logic [INSTR_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]      r_rd;
   logic [AW-1:0]      r_wr;
   logic [CW-1:0]      r_count;
   logic [AW-1:0]      w_rd1;

   assign w_rd1   = r_rd + AW'(1);
   assign o_count = r_count;
   assign o_head0 = (r_count != '0) ? r_mem[r_rd] : '0;
   assign o_head1 = (r_count > CW'(1)) ? r_mem[w_rd1] : '0;

   always_ff @(posedge clk) begin
      if (!rst || i_clr) begin
         r_rd    <= '0;
         r_wr    <= '0;
         r_count <= '0;
      end else begin
         if (i_push) r_wr <= r_wr + AW'(1);
         r_rd    <= r_rd + AW'(i_pop_n);
         r_count <= r_count + CW'(i_push) - CW'(i_pop_n);
      end
   end

   // Storage needs no reset: heads are gated by the count.
   always_ff @(posedge clk) begin
      if (i_push && !i_clr) r_mem[r_wr] <= i_wdata;
   end

   always_ff @(posedge clk) begin
      if (rst && !i_clr) begin
         assert (!(i_push && r_count == CW'(DEPTH) && i_pop_n == 2'd0));
         assert (CW'(i_pop_n) <= r_count);
      end
   end

endmodule

// File: rtl/instruction_pair_feeder.sv
// Fetch buffer feeding instruction pairs to the dual-issue scheduler.
// Sequential single-outstanding fetch into a small FIFO, flushed on redirect.
module instruction_pair_feeder
   import fetch_pkg::*;
#(
   parameter int          DEPTH    = 8,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               freeze1,
   input  logic               freeze2,
   input  logic               redirect,
   input  logic [31:0]        redirect_pc,
   output logic               imem_req,
   output logic [31:0]        imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               imem_valid,
   output logic [INSTR_W-1:0] instruction0,
   output logic [INSTR_W-1:0] instruction1,
   output logic               nothing_filled
);

   localparam int            CW   = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   fetch_state_t  r_state;
   fetch_state_t  w_state_nx;
   logic [31:0]   r_pc;
   logic [31:0]   w_pc_nx;
   logic          w_push;
   logic [1:0]    w_pop_n;
   logic [CW-1:0] w_count;
   logic [CW-1:0] w_count_nx;
   logic          w_room;

   assign w_push = (r_state == FETCH_WAIT) && imem_valid && !redirect;

   always_comb begin
      w_pop_n = 2'd0;
      if (!freeze1 && !freeze2 && !redirect && w_count != '0)
         w_pop_n = (w_count > CW'(1)) ? 2'd2 : 2'd1;
   end

   assign w_count_nx = redirect ? '0
                     : w_count + CW'(w_push) - CW'(w_pop_n);
   assign w_room     = w_count_nx < FULL;

   always_comb begin
      w_state_nx = r_state;
      w_pc_nx    = r_pc;
      unique case (r_state)
         FETCH_IDLE: begin
            if (!redirect && w_room) w_state_nx = FETCH_WAIT;
         end
         FETCH_WAIT: begin
            if (redirect) begin
               w_state_nx = imem_valid ? FETCH_IDLE : FETCH_DRAIN;
            end else if (imem_valid) begin
               w_pc_nx    = r_pc + PC_STEP;
               w_state_nx = w_room ? FETCH_WAIT : FETCH_IDLE;
            end
         end
         FETCH_DRAIN: begin
            if (imem_valid) w_state_nx = FETCH_IDLE;
         end
         default: w_state_nx = FETCH_IDLE;
      endcase
      if (redirect) w_pc_nx = redirect_pc;
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state <= FETCH_IDLE;
         r_pc    <= RESET_PC;
      end else begin
         r_state <= w_state_nx;
         r_pc    <= w_pc_nx;
      end
   end

   assign imem_req       = (r_state == FETCH_WAIT);
   assign imem_addr      = r_pc;
   assign nothing_filled = (w_count == '0);

   instr_pair_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (redirect),
      .i_push  (w_push),
      .i_wdata (imem_rdata),
      .i_pop_n (w_pop_n),
      .o_head0 (instruction0),
      .o_head1 (instruction1),
      .o_count (w_count)
   );

endmodule

// File: doc/instruction_pair_feeder.md
# instruction_pair_feeder

Front-end fetch buffer that supplies the dual-issue scheduler with instruction pairs. It fetches 32-bit words sequentially from instruction memory over a single-outstanding request/valid handshake and queues them in a small FIFO. It presents the two oldest words as `instruction0`/`instruction1` and pops them when the scheduler's freezes allow a new pair to latch. It also raises `nothing_filled` when the queue is empty and flushes on a PC redirect.

## Interface
- `DEPTH`, 8: FIFO entries (32-bit words); power of two, ≥ 4
- `RESET_PC`, 32'h0000_0000: first fetch address after reset
- `clk`  in  1  clock; all state updates on rising edge
- `rst`  in  1  reset; synchronous, active-low (0 = reset)
- `freeze1`  in  1  scheduler lane-1 freeze
- `freeze2`  in  1  scheduler lane-2 freeze
- `redirect`  in  1  flush the queue and restart fetch at `redirect_pc`
- `redirect_pc`  in  32  new fetch address; word-aligned
- `imem_req`  out  1  fetch request; held until `imem_valid`
- `imem_addr`  out  32  fetch address; stable while `imem_req`=1
- `imem_rdata`  in  32  fetched word; valid only with `imem_valid`
- `imem_valid`  in  1  one-cycle response strobe for the outstanding request
- `instruction0`  out  32  oldest queued word, or 0 when the queue is empty
- `instruction1`  out  32  second-oldest queued word, or 0 when count < 2
- `nothing_filled`  out  1  1 when the queue is empty (count == 0)

## Operation
- FIFO state: read pointer, write pointer, `count` (width $clog2(DEPTH)+1). Pointers wrap modulo DEPTH.
- Output side is combinational from stored entries: `instruction0 = mem[rd]`, `instruction1 = mem[rd+1]`, each gated to 0 when its entry is absent. Words are passed through unmodified; a fetched 0 word is forwarded as-is.
- Pop condition: `!freeze1 && !freeze2 && !redirect && count > 0`. The pop amount is min(count, 2), and the read pointer advances by the same amount.
- Push: one word on `imem_valid` when state is FETCH_WAIT and `redirect`=0.
- Push and pop in the same cycle are allowed: `count_next = count + push − pop`.
- Fetch FSM, states in the shared enum:
  - FETCH_IDLE: `imem_req`=0. Moves to FETCH_WAIT when `count_next < DEPTH` and `redirect`=0.
  - FETCH_WAIT: `imem_req`=1, `imem_addr=pc`.
    - On `imem_valid`: push, then `pc += 4`. Stay in FETCH_WAIT if `count_next < DEPTH`, otherwise go to FETCH_IDLE.
    - On `redirect` with `imem_valid`: discard the response, load `pc = redirect_pc`, go to FETCH_IDLE.
    - On `redirect` without `imem_valid`: load `pc = redirect_pc`, go to FETCH_DRAIN.
  - FETCH_DRAIN: `imem_req`=0. Wait for `imem_valid`, discard that word, go to FETCH_IDLE. Memory must complete any request it has seen, even after `req` drops.
- Redirect in any state: clear pointers and `count` and load `pc = redirect_pc`. Redirect wins over a push or pop in the same cycle.
- Full: no request is issued while `count_next == DEPTH`. An overflow push is impossible by construction; an assertion checks it.
- Empty: `nothing_filled`=1, both instructions are 0, no pop occurs.

## Timing
- Reset values: `imem_req`=0, `imem_addr`=RESET_PC, `nothing_filled`=1, `instruction0`=`instruction1`=0; `pc`=RESET_PC, `count`=0, state FETCH_IDLE.
- Reset asserted mid-transaction: all state returns to reset values; an in-flight `imem_valid` arriving after reset is ignored because the state is FETCH_IDLE.
- Request latency: `imem_req` rises 1 cycle after the FETCH_IDLE→FETCH_WAIT decision; first request is on the 2nd cycle after reset release.
- Write-to-output latency: a word pushed at edge N is visible on `instruction0`/`1` in the cycle after edge N.
- The scheduler latches the pair at the same edge where the feeder pops, so the pair shown during a cycle with both freezes low is consumed exactly once.
- Throughput: 1 word per cycle with a zero-wait-state memory; consumption up to 2 words per cycle.
- After a redirect, `nothing_filled`=1 from the next cycle until the first new-path word is pushed.

## Structure
- Shared package `fetch_pkg`:
  - `fetch_state_t` enum {FETCH_IDLE, FETCH_WAIT, FETCH_DRAIN}
  - `INSTR_W`=32
  - `PC_STEP`=4
- Sub-module `instr_pair_fifo`: storage, pointers, and count, with a 1-word push, a 0/1/2-word pop, a synchronous clear, and dual head read ports.
- The top level holds the FSM, `pc`, and the pop/redirect logic.

## Test plan
- Reset then a zero-wait memory returning PC-as-data, freezes low:
  - `imem_addr` sequence 0x0, 0x4, 0x8, …
  - pairs (0x0,0x4), (0x8,0xC) consumed in order
  - no word duplicated or lost.
- Both freezes held high with DEPTH=8: after 8 pushes `imem_req` drops and `count`=8. Release both freezes: two words pop per cycle and fetching resumes.
- Odd count: exactly 1 word queued, freezes low → `instruction0`=word, `instruction1`=0, pop 1, `nothing_filled`=1 next cycle.
- freeze1=0, freeze2=1 for 2 cycles → no pop, pair held stable; both low → pop 2.
- Redirect to 0x100 while in FETCH_WAIT with `imem_valid` 3 cycles later:
  - state is FETCH_DRAIN and the stale word is discarded
  - the next `imem_addr` is 0x100
  - the queue is empty in the intervening cycles.
- Same-cycle redirect, `imem_valid`, and pop: the queue is cleared, the response is dropped, `pc`=redirect_pc. Also drive `rst`=0 mid-WAIT: all outputs return to reset values.
